arbitro_escritura_banco: RTL and testbench
==========================================

Name: arbitro_escritura_banco

Overview:
- Shares the single register-bank write port (RegWrite/Dir/Di) between two producers: the ALU writeback path and the memory (load) path.
- Also keeps a per-register busy scoreboard so decode can stall on a read-after-write hazard.
- Sits between the execute/memory stages and the register bank. Its outputs drive the bank's write inputs directly.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- NREG, 32, number of registers tracked by the scoreboard (2**ADDR_W)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- alu_valid  input  1  ALU has a writeback pending
- alu_dir  input  ADDR_W  ALU destination register
- alu_dato  input  DATA_W  ALU result
- alu_ready  output  1  ALU request granted this cycle
- mem_valid  input  1  load unit has a writeback pending
- mem_dir  input  ADDR_W  load destination register
- mem_dato  input  DATA_W  load data
- mem_ready  output  1  load request granted this cycle
- res_valid  input  1  decode issues an instruction that will write res_dir
- res_dir  input  ADDR_W  register to mark busy
- RA1  input  ADDR_W  decode source register 1
- RA2  input  ADDR_W  decode source register 2
- stall  output  1  RA1 or RA2 is busy
- RegWrite  output  1  registered write enable to bank
- Dir  output  ADDR_W  registered write address to bank
- Di  output  DATA_W  registered write data to bank

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - RegWrite=0, Dir=0, Di=0.
  - busy[NREG-1:0]=0.
  - Priority pointer prio=ALU.
  - alu_ready=0 and mem_ready=0 while rst=1.
- Handshake:
  - A transfer occurs on a cycle where valid&ready.
  - ready is combinational from valid and prio.
  - A requester holding valid with ready=0 must keep dir/dato stable. The arbiter does not latch unaccepted requests.
- Arbitration, one grant per cycle:
  - Neither valid: no grant. Next cycle RegWrite=0; Dir and Di hold their last values.
  - Only one valid: grant it, and prio <= the other requester.
  - Both valid: grant the requester named by prio, and prio <= the other requester.
  - Result: strict alternation under contention. No requester waits more than one cycle.
- Latency: exactly one cycle. The granted dir/dato appear on Dir/Di with RegWrite=1 on the cycle after the grant edge. RegWrite is high for exactly one cycle per grant.
- Register 0 is not special-cased; writes to it pass through.
- Scoreboard:
  - res_valid=1 sets busy[res_dir] at the clock edge.
  - A grant clears busy[granted dir] at the same edge that loads Dir/Di. The register reads non-busy on the cycle RegWrite=1. The bank writes combinationally, so a same-cycle read returns Di.
  - Set and clear of the same address on one edge: set wins (new producer outstanding).
  - Reserve of an already-busy register: stays busy. One outstanding producer per register is supported; a single writeback clears it.
  - Writeback to a non-busy register: allowed. Busy stays 0.
- stall = busy[RA1] | busy[RA2]. Combinational from the current busy state; does not depend on same-cycle res_valid.
- Reset mid-operation:
  - Pending grants are dropped. RegWrite is 0 the cycle after the rst edge.
  - All busy bits clear, and prio returns to ALU.
  - Requesters must re-present after reset.

Test Plan:
- Reset with both valid: assert rst 2 cycles with alu_valid=mem_valid=1 -> alu_ready=mem_ready=0, RegWrite=0, Dir=0, Di=0, stall=0.
- Single requester: alu_valid=1, alu_dir=5, alu_dato=32'hCAFE0001 for 1 cycle -> alu_ready=1 that cycle; next cycle RegWrite=1, Dir=5, Di=32'hCAFE0001; following cycle RegWrite=0.
- Contention round-robin: both valid 4 cycles (alu_dir=1/dato=11, mem_dir=2/dato=22, held) -> grants ALU, MEM, ALU, MEM; RegWrite=1 every cycle from cycle 2 with Dir sequence 1,2,1,2.
- Hazard stall: res_valid=1, res_dir=7; next cycle RA1=7 -> stall=1. mem writes dir 7 after 3 cycles -> stall=0 on the RegWrite=1 cycle with Dir=7.
- Set/clear collision: busy[9]=1, grant alu_dir=9 on the same cycle as res_valid=1, res_dir=9 -> after the edge busy[9]=1 (stall=1 with RA2=9), RegWrite=1, Dir=9.
- Reset mid-stream: during alternating grants with busy[3]=1, pulse rst 1 cycle -> next cycle RegWrite=0, stall=0 with RA1=3; first post-reset contention grants ALU.

Source files
------------

// File: rtl/arbitro_escritura_banco_if.sv
// Bundle of the two writeback requesters, the decode reservation/hazard port
// and the registered write port that drives the register bank.
interface arbitro_escritura_banco_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dir;
    logic [DATA_W-1:0] alu_dato;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_dir;
    logic [DATA_W-1:0] mem_dato;
    logic              mem_ready;

    logic              res_valid;
    logic [ADDR_W-1:0] res_dir;
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic              stall;

    logic              RegWrite;
    logic [ADDR_W-1:0] Dir;
    logic [DATA_W-1:0] Di;

    modport slave (
        input  alu_valid, alu_dir, alu_dato,
        input  mem_valid, mem_dir, mem_dato,
        input  res_valid, res_dir, RA1, RA2,
        output alu_ready, mem_ready, stall,
        output RegWrite, Dir, Di
    );

    modport master (
        output alu_valid, alu_dir, alu_dato,
        output mem_valid, mem_dir, mem_dato,
        output res_valid, res_dir, RA1, RA2,
        input  alu_ready, mem_ready, stall,
        input  RegWrite, Dir, Di
    );
endinterface

// File: rtl/arbitro_escritura_banco.sv
// Round-robin arbiter for the single register-bank write port (ALU vs load),
// plus a per-register busy scoreboard that drives the decode stall.
module arbitro_escritura_banco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    arbitro_escritura_banco_if.slave bus
);

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_t;

    prio_t             r_prio;
    prio_t             w_prio_next;
    logic              w_alu_grant;
    logic              w_mem_grant;
    logic [ADDR_W-1:0] w_wr_dir;
    logic [DATA_W-1:0] w_wr_dato;

    logic              r_regwrite;
    logic [ADDR_W-1:0] r_dir;
    logic [DATA_W-1:0] r_di;

    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        w_prio_next = r_prio;
        if (!rst) begin
            if (bus.alu_valid && (!bus.mem_valid || r_prio == PRIO_ALU)) begin
                w_alu_grant = 1'b1;
                w_prio_next = PRIO_MEM;
            end else if (bus.mem_valid) begin
                w_mem_grant = 1'b1;
                w_prio_next = PRIO_ALU;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= PRIO_ALU;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    always_comb begin
        w_wr_dir  = bus.alu_dir;
        w_wr_dato = bus.alu_dato;
        if (w_mem_grant) begin
            w_wr_dir  = bus.mem_dir;
            w_wr_dato = bus.mem_dato;
        end
    end

    // Dir/Di only load on a grant and hold otherwise; RegWrite is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_dir      <= '0;
            r_di       <= '0;
        end else begin
            r_regwrite <= w_alu_grant | w_mem_grant;
            if (w_alu_grant || w_mem_grant) begin
                r_dir <= w_wr_dir;
                r_di  <= w_wr_dato;
            end
        end
    end

    // Clear first, then set: a same-edge reservation of the written register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_alu_grant || w_mem_grant) begin
            w_busy_next[w_wr_dir] = 1'b0;
        end
        if (bus.res_valid) begin
            w_busy_next[bus.res_dir] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign bus.alu_ready = w_alu_grant;
    assign bus.mem_ready = w_mem_grant;
    assign bus.stall     = r_busy[bus.RA1] | r_busy[bus.RA2];
    assign bus.RegWrite  = r_regwrite;
    assign bus.Dir       = r_dir;
    assign bus.Di        = r_di;

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Self-checking bench for arbitro_escritura_banco: directed scenarios plus a
// randomized run against a behavioural model of arbitration and scoreboard.
module tb_arbitro_escritura_banco;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arbitro_escritura_banco_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    arbitro_escritura_banco #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who gets the port, what the bank sees next, which registers are owed a write.
    bit          m_busy [NR];
    bit          m_prio_alu;
    bit          m_we;
    logic [AW-1:0] m_dir;
    logic [DW-1:0] m_di;

    // 0 = nobody, 1 = ALU, 2 = load unit
    function automatic int model_grant();
        if (rst) return 0;
        if (bus.alu_valid && bus.mem_valid) return m_prio_alu ? 1 : 2;
        if (bus.alu_valid) return 1;
        if (bus.mem_valid) return 2;
        return 0;
    endfunction

    function automatic bit model_stall();
        return m_busy[bus.RA1] | m_busy[bus.RA2];
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (rst) begin
            foreach (m_busy[k]) m_busy[k] = 1'b0;
            m_prio_alu = 1'b1;
            m_we  = 1'b0;
            m_dir = '0;
            m_di  = '0;
        end else begin
            m_we = (g != 0);
            if (g == 1) begin
                m_dir = bus.alu_dir;
                m_di  = bus.alu_dato;
                m_prio_alu = 1'b0;
            end else if (g == 2) begin
                m_dir = bus.mem_dir;
                m_di  = bus.mem_dato;
                m_prio_alu = 1'b1;
            end
            if (g != 0) m_busy[m_dir] = 1'b0;
            if (bus.res_valid) m_busy[bus.res_dir] = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_dir   = '0;
        bus.alu_dato  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_dir   = '0;
        bus.mem_dato  = '0;
        bus.res_valid = 1'b0;
        bus.res_dir   = '0;
        bus.RA1       = '0;
        bus.RA2       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.alu_valid = 1'b1;
        bus.alu_dir   = 5'd4;
        bus.alu_dato  = 32'h1111_2222;
        bus.mem_valid = 1'b1;
        bus.mem_dir   = 5'd6;
        bus.mem_dato  = 32'h3333_4444;
        bus.RA1       = 5'd7;
        bus.RA2       = 5'd9;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (bus.alu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_alu_ready cycle %0d got=%b exp=0", c, bus.alu_ready);
            end
            n_checks++;
            if (bus.mem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mem_ready cycle %0d got=%b exp=0", c, bus.mem_ready);
            end
            tick();
        end
        n_checks++;
        if (bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regwrite got=%b exp=0", bus.RegWrite);
        end
        n_checks++;
        if (bus.Dir !== '0) begin
            n_fail++;
            $display("FAIL reset_dir got=%0d exp=0", bus.Dir);
        end
        n_checks++;
        if (bus.Di !== '0) begin
            n_fail++;
            $display("FAIL reset_di got=%h exp=0", bus.Di);
        end
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got=%b exp=0", bus.stall);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        idle_inputs();
        bus.alu_valid = 1'b1;
        bus.alu_dir   = 5'd5;
        bus.alu_dato  = 32'hCAFE0001;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready got alu=%b mem=%b exp alu=1 mem=0", bus.alu_ready, bus.mem_ready);
        end
        tick();
        bus.alu_valid = 1'b0;
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.Dir !== 5'd5 || bus.Di !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL single_write got we=%b dir=%0d di=%h exp we=1 dir=5 di=cafe0001",
                     bus.RegWrite, bus.Dir, bus.Di);
        end
        tick();
        n_checks++;
        if (bus.RegWrite !== 1'b0 || bus.Dir !== 5'd5) begin
            n_fail++;
            $display("FAIL single_pulse got we=%b dir=%0d exp we=0 dir=5", bus.RegWrite, bus.Dir);
        end
    endtask

    task automatic test_contention();
        bit alu_turn;
        do_reset();
        bus.alu_valid = 1'b1;
        bus.alu_dir   = 5'd1;
        bus.alu_dato  = 32'd11;
        bus.mem_valid = 1'b1;
        bus.mem_dir   = 5'd2;
        bus.mem_dato  = 32'd22;
        for (int i = 0; i < 4; i++) begin
            alu_turn = (i % 2 == 0);
            #1;
            n_checks++;
            if (bus.alu_ready !== alu_turn || bus.mem_ready !== !alu_turn) begin
                n_fail++;
                $display("FAIL contention_grant %0d got alu=%b mem=%b exp alu=%b mem=%b",
                         i, bus.alu_ready, bus.mem_ready, alu_turn, !alu_turn);
            end
            tick();
            n_checks++;
            if (bus.RegWrite !== 1'b1 || bus.Dir !== (alu_turn ? 5'd1 : 5'd2) ||
                bus.Di !== (alu_turn ? 32'd11 : 32'd22)) begin
                n_fail++;
                $display("FAIL contention_write %0d got we=%b dir=%0d di=%0d exp we=1 dir=%0d",
                         i, bus.RegWrite, bus.Dir, bus.Di, alu_turn ? 1 : 2);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        idle_inputs();
        bus.res_valid = 1'b1;
        bus.res_dir   = 5'd7;
        tick();
        bus.res_valid = 1'b0;
        bus.RA1       = 5'd7;
        bus.RA2       = 5'd0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (bus.stall !== 1'b1) begin
                n_fail++;
                $display("FAIL hazard_stall %0d got=%b exp=1", c, bus.stall);
            end
            tick();
        end
        bus.mem_valid = 1'b1;
        bus.mem_dir   = 5'd7;
        bus.mem_dato  = 32'd77;
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b1 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_grant got ready=%b stall=%b exp ready=1 stall=1", bus.mem_ready, bus.stall);
        end
        tick();
        bus.mem_valid = 1'b0;
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.Dir !== 5'd7 || bus.Di !== 32'd77 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_release got we=%b dir=%0d di=%0d stall=%b exp we=1 dir=7 di=77 stall=0",
                     bus.RegWrite, bus.Dir, bus.Di, bus.stall);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        idle_inputs();
        bus.res_valid = 1'b1;
        bus.res_dir   = 5'd9;
        tick();
        bus.alu_valid = 1'b1;
        bus.alu_dir   = 5'd9;
        bus.alu_dato  = 32'd99;
        bus.RA1       = 5'd0;
        bus.RA2       = 5'd9;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_grant got ready=%b stall=%b exp ready=1 stall=1", bus.alu_ready, bus.stall);
        end
        tick();
        bus.alu_valid = 1'b0;
        bus.res_valid = 1'b0;
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.Dir !== 5'd9 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_setwins got we=%b dir=%0d stall=%b exp we=1 dir=9 stall=1",
                     bus.RegWrite, bus.Dir, bus.stall);
        end
        bus.mem_valid = 1'b1;
        bus.mem_dir   = 5'd9;
        bus.mem_dato  = 32'd999;
        tick();
        bus.mem_valid = 1'b0;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.Di !== 32'd999) begin
            n_fail++;
            $display("FAIL collision_clear got stall=%b di=%0d exp stall=0 di=999", bus.stall, bus.Di);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.res_valid = 1'b1;
        bus.res_dir   = 5'd3;
        tick();
        bus.res_valid = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_dir   = 5'd1;
        bus.alu_dato  = 32'd101;
        bus.mem_valid = 1'b1;
        bus.mem_dir   = 5'd2;
        bus.mem_dato  = 32'd202;
        tick();
        tick();
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.Dir !== 5'd2) begin
            n_fail++;
            $display("FAIL midreset_stream got we=%b dir=%0d exp we=1 dir=2", bus.RegWrite, bus.Dir);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ready got alu=%b mem=%b exp 0 0", bus.alu_ready, bus.mem_ready);
        end
        tick();
        rst = 1'b0;
        bus.RA1 = 5'd3;
        bus.RA2 = 5'd0;
        n_checks++;
        if (bus.RegWrite !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_after got we=%b stall=%b exp we=0 stall=0", bus.RegWrite, bus.stall);
        end
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_prio got alu=%b mem=%b exp alu=1 mem=0", bus.alu_ready, bus.mem_ready);
        end
        tick();
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.Dir !== 5'd1 || bus.Di !== 32'd101) begin
            n_fail++;
            $display("FAIL midreset_first got we=%b dir=%0d di=%0d exp we=1 dir=1 di=101",
                     bus.RegWrite, bus.Dir, bus.Di);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit a_hold = 1'b0;
        bit m_hold = 1'b0;
        int g;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!a_hold) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_dir   = AW'($urandom_range(0, NR - 1));
                bus.alu_dato  = DW'($urandom);
            end
            if (!m_hold) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_dir   = AW'($urandom_range(0, NR - 1));
                bus.mem_dato  = DW'($urandom);
            end
            bus.res_valid = ($urandom_range(0, 3) == 0);
            bus.res_dir   = AW'($urandom_range(0, NR - 1));
            bus.RA1       = AW'($urandom_range(0, NR - 1));
            bus.RA2       = AW'($urandom_range(0, NR - 1));
            #1;
            g = model_grant();
            n_checks++;
            if (bus.alu_ready !== (g == 1) || bus.mem_ready !== (g == 2)) begin
                n_fail++;
                $display("FAIL rand_ready %0d got alu=%b mem=%b exp grant=%0d", i, bus.alu_ready, bus.mem_ready, g);
            end
            n_checks++;
            if (bus.stall !== model_stall()) begin
                n_fail++;
                $display("FAIL rand_stall %0d got=%b exp=%b", i, bus.stall, model_stall());
            end
            a_hold = bus.alu_valid && (g != 1) && !rst;
            m_hold = bus.mem_valid && (g != 2) && !rst;
            tick();
            n_checks++;
            if (bus.RegWrite !== m_we || bus.Dir !== m_dir || bus.Di !== m_di) begin
                n_fail++;
                $display("FAIL rand_write %0d got we=%b dir=%0d di=%h exp we=%b dir=%0d di=%h",
                         i, bus.RegWrite, bus.Dir, bus.Di, m_we, m_dir, m_di);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_hazard();
        test_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
